// File: rtl/rv_pkg.sv
// Shared RV32 constants and the fetch buffer entry type.
// Used by the fetch front end and its bench.
package rv_pkg;

    localparam int unsigned XLEN = 32;

    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned OPCODE_MSB = 6;
    localparam int unsigned FUNC3_LSB  = 12;
    localparam int unsigned FUNC3_MSB  = 14;
    localparam int unsigned FUNC7_LSB  = 25;
    localparam int unsigned FUNC7_MSB  = 31;

    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer of {pc, instr} entries with flush.
// When empty, the read port keeps showing the last head entry.
module fetch_fifo
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         wr_en,
    input  fetch_entry_t wr_data,
    input  logic         rd_en,
    output fetch_entry_t rd_data,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t mem_d [DEPTH];
    fetch_entry_t hold_q, hold_d;
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_wr, do_rd;

    always_comb begin
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty = (wr_ptr_q == rd_ptr_q);
        count = wr_ptr_q - rd_ptr_q;
        do_wr = wr_en && !full && !flush;
        do_rd = rd_en && !empty;

        mem_d = mem_q;
        if (do_wr) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
        end

        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
        // Flush drops everything buffered; a same-cycle pop is subsumed by it.
        rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + {{AW{1'b0}}, do_rd};

        hold_d  = empty ? hold_q : mem_q[rd_ptr_q[AW-1:0]];
        rd_data = empty ? hold_q : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            hold_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            hold_q   <= hold_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: PC, credit-limited memory requests, response
// buffering and redirect handling, feeding decode over valid/ready.
module instr_fetch
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic [6:0]      func7
);

    localparam int unsigned     CW     = $clog2(DEPTH) + 1;
    localparam logic [CW+1:0]   DepthW = (CW+2)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic            req_en_q, req_en_d;

    logic            req_hs, rsp_drop, fifo_wr;
    logic [CW+1:0]   credit_used;
    logic [XLEN-1:0] redirect_target;
    logic            unused_redirect_bits;

    fetch_entry_t    fifo_wdata, fifo_rdata;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;

    assign unused_redirect_bits = ^redirect_pc[1:0];
    assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};

    always_comb begin
        // Dropped responses are also still outstanding, so they are counted twice.
        credit_used = {2'b00, outstanding_q} + {2'b00, drop_cnt_q} + {2'b00, fifo_count};
        imem_req_valid = req_en_q && !fifo_full && (credit_used < DepthW);
        imem_req_addr  = fetch_pc_q;
        req_hs         = imem_req_valid && imem_req_ready;
        rsp_drop       = (drop_cnt_q != '0);
        fifo_wr        = imem_rsp_valid && !rsp_drop && !redirect_valid;
        req_en_d       = 1'b1;

        outstanding_d = outstanding_q + CW'(req_hs) - CW'(imem_rsp_valid);

        if (redirect_valid) begin
            drop_cnt_d = outstanding_d;
        end else if (imem_rsp_valid && rsp_drop) begin
            drop_cnt_d = drop_cnt_q - 1'b1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end

        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
        end else if (req_hs) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end

        // Requests are sequential from the last redirect, so the PC of the next
        // kept response is a single running counter rather than a full queue.
        if (redirect_valid) begin
            rsp_pc_d = redirect_target;
        end else if (fifo_wr) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
        end else begin
            rsp_pc_d = rsp_pc_q;
        end

        fifo_wdata.pc    = rsp_pc_q;
        fifo_wdata.instr = imem_rsp_data;

        out_valid = !fifo_empty;
        out_pc    = fifo_rdata.pc;
        out_instr = fifo_rdata.instr;
        opcode    = out_instr[OPCODE_MSB:OPCODE_LSB];
        func3     = out_instr[FUNC3_MSB:FUNC3_LSB];
        func7     = out_instr[FUNC7_MSB:FUNC7_LSB];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            req_en_q      <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            req_en_q      <= req_en_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (redirect_valid),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (out_valid && out_ready),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: memory model, spec-level credit/drop model,
// redirect, wrap and asynchronous reset scenarios.
module tb_instr_fetch;
    import rv_pkg::*;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_instr;
    logic [6:0]  opcode, func7;
    logic [2:0]  func3;

    instr_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .opcode         (opcode),
        .func3          (func3),
        .func7          (func7)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] addr; } req_t;

    exp_t exp_q[$];
    req_t mem_q[$];

    int unsigned total = 0;
    int unsigned bad = 0;

    int          m_out, m_drop;
    logic [31:0] m_pc;
    bit          m_en;
    exp_t        last;
    bit          redir_chk;
    logic [31:0] redir_target;

    bit          c_out_ready, c_req_ready, c_rand_ready, c_redir, c_both;
    int          c_rsp_pct;
    logic [31:0] c_redir_pc, c_both_pc;
    bit          both_hit, wrap_hit;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] data_for(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A0_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        mem_q.delete();
        m_out = 0; m_drop = 0; m_pc = RESET_PC; m_en = 0;
        last = '0; redir_chk = 0;
    endtask

    task automatic step();
        bit   req_hs, out_hs, rsp;
        req_t r;
        exp_t f;
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            f = exp_q[0];
            chk("out_pc", out_pc, f.pc);
            chk("out_instr", out_instr, f.instr);
            last = f;
        end else begin
            chk("hold_pc", out_pc, last.pc);
            chk("hold_instr", out_instr, last.instr);
        end
        chk("req_valid", 32'(imem_req_valid),
            32'(m_en && (m_out + m_drop + exp_q.size() < DEPTH)));
        if (imem_req_valid) chk("req_addr", imem_req_addr, m_pc);

        rsp = (mem_q.size() > 0) && (($urandom % 100) < c_rsp_pct);
        imem_rsp_valid = rsp;
        imem_rsp_data  = 32'hDEAD_BEEF;
        if (rsp) begin
            r = mem_q.pop_front();
            imem_rsp_data = data_for(r.addr);
        end
        imem_req_ready = c_rand_ready ? 1'($urandom % 2) : c_req_ready;
        out_ready      = c_rand_ready ? 1'($urandom % 2) : c_out_ready;
        req_hs = imem_req_valid && imem_req_ready;
        out_hs = out_valid && out_ready;
        redirect_valid = c_redir;
        redirect_pc    = c_redir_pc;
        if (c_both && rsp && req_hs && m_drop == 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = c_both_pc;
            c_both = 0;
            both_hit = 1;
        end
        c_redir = 0;

        if (out_hs && exp_q.size() > 0) begin
            f = exp_q.pop_front();
            chk("opcode", 32'(opcode), 32'(f.instr[6:0]));
            chk("func3", 32'(func3), 32'(f.instr[14:12]));
            chk("func7", 32'(func7), 32'(f.instr[31:25]));
            if (redir_chk) begin
                chk("first_pc_after_redirect", f.pc, redir_target);
                redir_chk = 0;
            end
        end
        if (rsp) begin
            m_out--;
            if (m_drop > 0) m_drop--;
            else if (!redirect_valid) exp_q.push_back({r.pc, data_for(r.pc)});
        end
        if (req_hs) begin
            if (m_pc == 32'hFFFF_FFFC) wrap_hit = 1;
            mem_q.push_back({m_pc, imem_req_addr});
            m_pc = m_pc + 32'd4;
            m_out++;
        end
        if (redirect_valid) begin
            exp_q.delete();
            m_drop = m_out;
            m_pc = {redirect_pc[31:2], 2'b00};
            redir_chk = 1;
            redir_target = m_pc;
        end
        m_en = 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_pc"}, out_pc, 32'd0);
        chk({tag, "_out_instr"}, out_instr, 32'd0);
        chk({tag, "_fields"}, {12'd0, opcode, func3, func7}, 32'd0);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        chk({tag, "_req_addr"}, imem_req_addr, RESET_PC);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 chk("req_valid_before_first_edge", 32'(imem_req_valid), 32'd0);
        m_en = 1;
    endtask

    initial begin
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        redirect_valid = 0; redirect_pc = 0; out_ready = 0;
        c_out_ready = 1; c_req_ready = 1; c_rand_ready = 0; c_redir = 0; c_both = 0;
        c_rsp_pct = 100; c_redir_pc = 0; c_both_pc = 0; both_hit = 0; wrap_hit = 0;
        model_clear();
        #12;
        check_reset_outputs("reset");
        chk("nop_idle_word", NOP_WORD & 32'h7F, 32'h13);
        release_reset();

        // Steady fetch with a one-cycle memory.
        repeat (20) step();

        // Backpressure then release.
        c_out_ready = 0;
        repeat (10) step();
        chk("bp_full_out_valid", 32'(out_valid), 32'd1);
        chk("bp_req_stalled", 32'(imem_req_valid), 32'd0);
        c_out_ready = 1;
        repeat (10) step();

        // Redirect with two responses in flight; low bits ignored.
        c_rsp_pct = 0;
        for (int i = 0; i < 20 && m_out < 2; i++) step();
        chk("two_outstanding", 32'(m_out), 32'd2);
        c_redir = 1; c_redir_pc = 32'h0000_0103;
        step();
        c_rsp_pct = 100;
        repeat (15) step();
        chk("redirect_delivered", 32'(redir_chk), 32'd0);

        // Redirect coinciding with a response and a request handshake.
        c_rsp_pct = 60; c_both = 1; c_both_pc = 32'h0000_0300;
        for (int i = 0; i < 60 && c_both; i++) step();
        chk("same_cycle_redirect_hit", 32'(both_hit), 32'd1);
        c_rsp_pct = 100;
        repeat (15) step();
        chk("same_cycle_redirect_delivered", 32'(redir_chk), 32'd0);

        // Back-to-back redirects, second one near the top of the address space.
        c_redir = 1; c_redir_pc = 32'h0000_0200; step();
        c_redir = 1; c_redir_pc = 32'hFFFF_FFF8; step();
        repeat (20) step();
        chk("wrap_hit", 32'(wrap_hit), 32'd1);

        // Random traffic with occasional redirects.
        c_rand_ready = 1; c_rsp_pct = 70;
        for (int i = 0; i < 300; i++) begin
            if (($urandom % 100) < 5) begin
                c_redir = 1;
                c_redir_pc = $urandom;
            end
            step();
        end
        c_rand_ready = 0; c_rsp_pct = 100;
        repeat (10) step();

        // Asynchronous reset in the middle of a burst.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        imem_rsp_valid = 0; redirect_valid = 0;
        model_clear();
        @(negedge clk);
        release_reset();
        redir_chk = 1; redir_target = RESET_PC;
        repeat (15) step();
        chk("restart_at_reset_pc", 32'(redir_chk), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
